// File: rtl/cpu_instruction_memory_responder.sv
// ----------------------------------------------------------------------------
// cpu_instruction_memory_responder
//
// Memory-side responder for the instruction cache fill port. Instruction read
// requests are collected in a small address FIFO. The single-port program RAM
// is shared with the CPU data port, and the data port always has priority over
// queued instruction reads. Each word read for the cache is returned with its
// address, which is carried alongside the RAM access in a one-entry tag
// register.
//
// Ports
//   CLK, RSTb                 clock; asynchronous active-low reset
//   cache_address/rd_req      instruction read request from the cache
//   cache_will_queue          request accepted this cycle (combinational)
//   cache_success             returned word valid this cycle
//   cache_requested_address   address of the returned word
//   cache_data                returned word (RAM read data pass-through)
//   dport_address/rd/wr/data  CPU data-port access (a write wins over a read)
//   dport_success             data-port access completed (cycle after grant)
//   dport_data                data-port read data (RAM read data pass-through)
//   ram_*                     synchronous program RAM, 1-cycle read latency
// ----------------------------------------------------------------------------
module cpu_instruction_memory_responder #(
  parameter int ADDRESS_BITS     = 15,
  parameter int DATA_BITS        = 16,
  parameter int QUEUE_DEPTH_BITS = 2
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] cache_address,
  input  logic                    cache_rd_req,
  output logic                    cache_will_queue,
  output logic                    cache_success,
  output logic [ADDRESS_BITS-1:0] cache_requested_address,
  output logic [DATA_BITS-1:0]    cache_data,
  input  logic [ADDRESS_BITS-1:0] dport_address,
  input  logic                    dport_rd_req,
  input  logic                    dport_wr_req,
  input  logic [DATA_BITS-1:0]    dport_wr_data,
  output logic                    dport_success,
  output logic [DATA_BITS-1:0]    dport_data,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic                    ram_rd,
  output logic                    ram_wr,
  output logic [DATA_BITS-1:0]    ram_wr_data,
  input  logic [DATA_BITS-1:0]    ram_rd_data
);

  localparam int QUEUE_DEPTH = 1 << QUEUE_DEPTH_BITS;
  localparam logic [QUEUE_DEPTH_BITS:0]   COUNT_FULL = (QUEUE_DEPTH_BITS + 1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_DEPTH_BITS:0]   COUNT_ONE  = (QUEUE_DEPTH_BITS + 1)'(1);
  localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ONE    = QUEUE_DEPTH_BITS'(1);

  // Address FIFO storage; no reset needed since count/pointers qualify it.
  logic [ADDRESS_BITS-1:0]     queue_mem [0:QUEUE_DEPTH-1];
  logic [QUEUE_DEPTH_BITS-1:0] wr_ptr_reg, wr_ptr_next;
  logic [QUEUE_DEPTH_BITS-1:0] rd_ptr_reg, rd_ptr_next;
  logic [QUEUE_DEPTH_BITS:0]   count_reg, count_next;
  logic [ADDRESS_BITS-1:0]     queue_head;

  // Return-side registers.
  logic                    inst_tag_valid_reg;
  logic [ADDRESS_BITS-1:0] inst_tag_reg;
  logic                    dport_success_reg;

  // Grant decode.
  logic dport_wr_grant;
  logic dport_rd_grant;
  logic inst_grant;
  logic push;
  logic pop;

  assign queue_head = queue_mem[rd_ptr_reg];

  // Acceptance looks only at the registered count: a pop in the same cycle
  // does not free a slot for a push when the queue is full. RSTb gates the
  // strobes so nothing is accepted or issued while reset is held.
  assign cache_will_queue = cache_rd_req & (count_reg != COUNT_FULL) & RSTb;
  assign push             = cache_will_queue;

  always_comb begin
    dport_wr_grant = 1'b0;
    dport_rd_grant = 1'b0;
    inst_grant     = 1'b0;
    if (RSTb) begin
      if (dport_wr_req) begin
        dport_wr_grant = 1'b1;
      end else if (dport_rd_req) begin
        dport_rd_grant = 1'b1;
      end else if (count_reg != '0) begin
        inst_grant = 1'b1;
      end
    end
  end

  assign pop = inst_grant;

  // RAM side. When idle the address follows the queue head (don't-care).
  assign ram_address = (dport_wr_req | dport_rd_req) ? dport_address : queue_head;
  assign ram_rd      = dport_rd_grant | inst_grant;
  assign ram_wr      = dport_wr_grant;
  assign ram_wr_data = dport_wr_data;

  // Queue bookkeeping.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      queue_mem[wr_ptr_reg] <= cache_address;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      inst_tag_valid_reg <= 1'b0;
      inst_tag_reg       <= '0;
      dport_success_reg  <= 1'b0;
    end else begin
      wr_ptr_reg         <= wr_ptr_next;
      rd_ptr_reg         <= rd_ptr_next;
      count_reg          <= count_next;
      // The tag travels with the RAM read so it lines up with ram_rd_data.
      inst_tag_valid_reg <= inst_grant;
      if (inst_grant) begin
        inst_tag_reg <= queue_head;
      end
      dport_success_reg  <= dport_wr_grant | dport_rd_grant;
    end
  end

  assign cache_success           = inst_tag_valid_reg;
  assign cache_requested_address = inst_tag_reg;
  assign cache_data              = ram_rd_data;
  assign dport_success           = dport_success_reg;
  assign dport_data              = ram_rd_data;

endmodule
